// File: rtl/blit_mem_arbiter.sv
// -----------------------------------------------------------------------------
// blit_mem_arbiter
//
// Shares the single SDRAM controller port between three requesters: the CPU
// data port, the blitter read port (cache line fills) and the blitter write
// port (write FIFO drain). Only one transaction is outstanding at a time, and
// read beats are routed back to the requester that issued the read.
//
// Arbitration is round-robin in the order CPU -> BLITR -> BLITW -> CPU. The
// search starts at the requester after the last owner. Blitter writes may run
// back-to-back for up to WRITE_RUN words, but only while nobody else is waiting.
//
// Parameters
//   WRITE_RUN : max consecutive blitter-write words before rotation (1..255)
//   ADDR_W    : word address width
//
// Ports
//   clock, reset_n          : system clock, asynchronous active-low reset
//   cpu_*                   : CPU request/ack, read data return
//   blitr_*                 : blitter line-fill read request/ack, read data return
//   blitw_*                 : blitter write FIFO head (request = FIFO not empty)
//   mem_*                   : SDRAM controller command and read data return
//
// Optional feature (macro BLIT_MEM_ARBITER_STATS_EN)
//   Adds stat_clear and four saturating 32-bit counters: CPU grants, BLITR
//   grants, BLITW words, and cycles a blitter request waited without an ack.
//   Arbitration behaviour is identical with or without the macro.
// -----------------------------------------------------------------------------

// Simulation checker: read beats may only reach the requester that owns the
// current read phase.
module blit_mem_arbiter_checker (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       rdata_phase,
    input  logic [1:0] owner,
    input  logic       cpu_valid,
    input  logic       cpu_complete,
    input  logic       blitr_valid,
    input  logic       blitr_complete
);

    // Owner encoding matches the arbiter: 1 = CPU, 2 = BLITR.
    a_cpu_route: assert property (@(posedge clock) disable iff (!reset_n)
        (cpu_valid || cpu_complete) |-> (rdata_phase && (owner == 2'd1)));

    a_blitr_route: assert property (@(posedge clock) disable iff (!reset_n)
        (blitr_valid || blitr_complete) |-> (rdata_phase && (owner == 2'd2)));

endmodule

module blit_mem_arbiter #(
    parameter int WRITE_RUN = 8,
    parameter int ADDR_W    = 26
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              cpu_request,
    input  logic              cpu_write,
    input  logic [ADDR_W-1:0] cpu_address,
    input  logic [31:0]       cpu_wdata,
    input  logic [3:0]        cpu_byte_en,
    output logic              cpu_ack,
    output logic [31:0]       cpu_rdata,
    output logic              cpu_valid,
    output logic              cpu_complete,
    input  logic              blitr_request,
    input  logic [ADDR_W-1:0] blitr_address,
    output logic              blitr_ack,
    output logic [31:0]       blitr_rdata,
    output logic              blitr_valid,
    output logic              blitr_complete,
    input  logic              blitw_request,
    input  logic [ADDR_W-1:0] blitw_address,
    input  logic [31:0]       blitw_wdata,
    input  logic [3:0]        blitw_byte_en,
    output logic              blitw_ack,
    output logic              mem_request,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_address,
    output logic [31:0]       mem_wdata,
    output logic [3:0]        mem_byte_en,
    input  logic              mem_ack,
    input  logic [31:0]       mem_rdata,
    input  logic              mem_valid,
    input  logic              mem_complete
`ifdef BLIT_MEM_ARBITER_STATS_EN
    ,
    input  logic              stat_clear,
    output logic [31:0]       stat_cpu_grants,
    output logic [31:0]       stat_blitr_grants,
    output logic [31:0]       stat_blitw_words,
    output logic [31:0]       stat_blit_wait_cycles
`endif
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_RDATA = 2'd2
    } state_t;

    localparam logic [1:0] OWN_NONE  = 2'd0;
    localparam logic [1:0] OWN_CPU   = 2'd1;
    localparam logic [1:0] OWN_BLITR = 2'd2;
    localparam logic [1:0] OWN_BLITW = 2'd3;

    state_t     state_r;
    state_t     state_next_s;
    logic [1:0] owner_r;
    logic [1:0] owner_next_s;
    logic [1:0] rr_ptr_r;        // first requester to consider in IDLE
    logic [1:0] rr_next_s;
    logic [7:0] run_cnt_r;       // BLITW words already granted in this run
    logic [7:0] run_next_s;
    logic [8:0] run_inc_s;
    logic [1:0] pick_s;
    logic       owner_req_s;
    logic       owner_is_read_s;
    logic       other_pending_s;
    logic       issue_ack_s;
    logic       rdata_phase_s;

    // Round-robin successor: CPU -> BLITR -> BLITW -> CPU.
    function automatic logic [1:0] rr_after(input logic [1:0] own);
        case (own)
            OWN_CPU:   rr_after = OWN_BLITR;
            OWN_BLITR: rr_after = OWN_BLITW;
            OWN_BLITW: rr_after = OWN_CPU;
            default:   rr_after = OWN_CPU;
        endcase
    endfunction

    // Round-robin pick among the current requests, starting at rr_ptr_r.
    always_comb begin
        pick_s = OWN_NONE;
        case (rr_ptr_r)
            OWN_BLITR: begin
                if (blitr_request)      pick_s = OWN_BLITR;
                else if (blitw_request) pick_s = OWN_BLITW;
                else if (cpu_request)   pick_s = OWN_CPU;
                else                    pick_s = OWN_NONE;
            end
            OWN_BLITW: begin
                if (blitw_request)      pick_s = OWN_BLITW;
                else if (cpu_request)   pick_s = OWN_CPU;
                else if (blitr_request) pick_s = OWN_BLITR;
                else                    pick_s = OWN_NONE;
            end
            default: begin
                if (cpu_request)        pick_s = OWN_CPU;
                else if (blitr_request) pick_s = OWN_BLITR;
                else if (blitw_request) pick_s = OWN_BLITW;
                else                    pick_s = OWN_NONE;
            end
        endcase
    end

    // Owner-side view: is the owner still requesting, and is it a read.
    always_comb begin
        owner_req_s     = 1'b0;
        owner_is_read_s = 1'b0;
        case (owner_r)
            OWN_CPU: begin
                owner_req_s     = cpu_request;
                owner_is_read_s = ~cpu_write;
            end
            OWN_BLITR: begin
                owner_req_s     = blitr_request;
                owner_is_read_s = 1'b1;
            end
            OWN_BLITW: begin
                owner_req_s     = blitw_request;
                owner_is_read_s = 1'b0;
            end
            default: begin
                owner_req_s     = 1'b0;
                owner_is_read_s = 1'b0;
            end
        endcase
    end

    // The controller ack only counts while we are actually presenting a request.
    assign issue_ack_s     = (state_r == ST_ISSUE) && owner_req_s && mem_ack;
    assign other_pending_s = cpu_request | blitr_request;
    assign run_inc_s       = {1'b0, run_cnt_r} + 9'd1;
    assign rdata_phase_s   = (state_r == ST_RDATA);

    // State, owner, round-robin pointer and write-run counter registers.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_r   <= ST_IDLE;
            owner_r   <= OWN_NONE;
            rr_ptr_r  <= OWN_CPU;
            run_cnt_r <= 8'd0;
        end else begin
            state_r   <= state_next_s;
            owner_r   <= owner_next_s;
            rr_ptr_r  <= rr_next_s;
            run_cnt_r <= run_next_s;
        end
    end

    // Next-state logic. The pointer moves past the owner at grant time, so a
    // forced rotation after a BLITW run needs no extra pointer update.
    always_comb begin
        state_next_s = state_r;
        owner_next_s = owner_r;
        rr_next_s    = rr_ptr_r;
        run_next_s   = run_cnt_r;
        case (state_r)
            ST_IDLE: begin
                if (pick_s != OWN_NONE) begin
                    state_next_s = ST_ISSUE;
                    owner_next_s = pick_s;
                    rr_next_s    = rr_after(pick_s);
                    run_next_s   = 8'd0;
                end else begin
                    owner_next_s = OWN_NONE;
                end
            end
            ST_ISSUE: begin
                if (!owner_req_s) begin
                    // Only the write FIFO can withdraw: it drained mid-run.
                    state_next_s = ST_IDLE;
                    owner_next_s = OWN_NONE;
                    run_next_s   = 8'd0;
                end else if (issue_ack_s) begin
                    if (owner_is_read_s) begin
                        state_next_s = ST_RDATA;
                    end else if (owner_r == OWN_BLITW) begin
                        if ((run_inc_s < 9'(WRITE_RUN)) && !other_pending_s) begin
                            run_next_s = run_inc_s[7:0];
                        end else begin
                            state_next_s = ST_IDLE;
                            owner_next_s = OWN_NONE;
                            run_next_s   = 8'd0;
                        end
                    end else begin
                        state_next_s = ST_IDLE;
                        owner_next_s = OWN_NONE;
                    end
                end else begin
                    state_next_s = ST_ISSUE;
                end
            end
            ST_RDATA: begin
                if (mem_complete) begin
                    state_next_s = ST_IDLE;
                    owner_next_s = OWN_NONE;
                end else begin
                    state_next_s = ST_RDATA;
                end
            end
            default: begin
                state_next_s = ST_IDLE;
                owner_next_s = OWN_NONE;
                run_next_s   = 8'd0;
            end
        endcase
    end

    // Outputs: command mux from the registered owner, acks and read data
    // passed through combinationally to the owner only.
    always_comb begin
        mem_request    = 1'b0;
        mem_write      = 1'b0;
        mem_address    = '0;
        mem_wdata      = 32'd0;
        mem_byte_en    = 4'd0;
        cpu_ack        = 1'b0;
        blitr_ack      = 1'b0;
        blitw_ack      = 1'b0;
        cpu_rdata      = 32'd0;
        cpu_valid      = 1'b0;
        cpu_complete   = 1'b0;
        blitr_rdata    = 32'd0;
        blitr_valid    = 1'b0;
        blitr_complete = 1'b0;
        case (state_r)
            ST_ISSUE: begin
                mem_request = owner_req_s;
                case (owner_r)
                    OWN_CPU: begin
                        mem_write   = cpu_write;
                        mem_address = cpu_address;
                        mem_wdata   = cpu_wdata;
                        mem_byte_en = cpu_write ? cpu_byte_en : 4'b1111;
                        cpu_ack     = issue_ack_s;
                    end
                    OWN_BLITR: begin
                        mem_write   = 1'b0;
                        mem_address = blitr_address;
                        mem_byte_en = 4'b1111;
                        blitr_ack   = issue_ack_s;
                    end
                    OWN_BLITW: begin
                        mem_write   = 1'b1;
                        mem_address = blitw_address;
                        mem_wdata   = blitw_wdata;
                        mem_byte_en = blitw_byte_en;
                        blitw_ack   = issue_ack_s;
                    end
                    default: begin
                        mem_request = 1'b0;
                    end
                endcase
            end
            ST_RDATA: begin
                case (owner_r)
                    OWN_CPU: begin
                        cpu_rdata    = mem_rdata;
                        cpu_valid    = mem_valid;
                        cpu_complete = mem_complete;
                    end
                    OWN_BLITR: begin
                        blitr_rdata    = mem_rdata;
                        blitr_valid    = mem_valid;
                        blitr_complete = mem_complete;
                    end
                    default: begin
                        cpu_valid = 1'b0;
                    end
                endcase
            end
            default: begin
                mem_request = 1'b0;
            end
        endcase
    end

    blit_mem_arbiter_checker u_checker (
        .clock          (clock),
        .reset_n        (reset_n),
        .rdata_phase    (rdata_phase_s),
        .owner          (owner_r),
        .cpu_valid      (cpu_valid),
        .cpu_complete   (cpu_complete),
        .blitr_valid    (blitr_valid),
        .blitr_complete (blitr_complete)
    );

`ifdef BLIT_MEM_ARBITER_STATS_EN
    // Saturating increment: the counter sticks at all-ones.
    function automatic logic [31:0] sat_inc32(input logic [31:0] value);
        if (value == 32'hFFFF_FFFF) begin
            sat_inc32 = value;
        end else begin
            sat_inc32 = value + 32'd1;
        end
    endfunction

    logic blit_waiting_s;
    assign blit_waiting_s = (blitr_request && !blitr_ack) || (blitw_request && !blitw_ack);

    // Statistics counters; stat_clear overrides any increment in the same cycle.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            stat_cpu_grants       <= 32'd0;
            stat_blitr_grants     <= 32'd0;
            stat_blitw_words      <= 32'd0;
            stat_blit_wait_cycles <= 32'd0;
        end else if (stat_clear) begin
            stat_cpu_grants       <= 32'd0;
            stat_blitr_grants     <= 32'd0;
            stat_blitw_words      <= 32'd0;
            stat_blit_wait_cycles <= 32'd0;
        end else begin
            if (cpu_ack)        stat_cpu_grants       <= sat_inc32(stat_cpu_grants);
            if (blitr_ack)      stat_blitr_grants     <= sat_inc32(stat_blitr_grants);
            if (blitw_ack)      stat_blitw_words      <= sat_inc32(stat_blitw_words);
            if (blit_waiting_s) stat_blit_wait_cycles <= sat_inc32(stat_blit_wait_cycles);
        end
    end
`endif

endmodule

// File: tb/tb_blit_mem_arbiter.sv
// -----------------------------------------------------------------------------
// Directed testbench for blit_mem_arbiter (WRITE_RUN = 8, ADDR_W = 26).
// Inputs are driven on the falling clock edge; combinational outputs are
// sampled 1 ns later, well away from the rising edge.
// -----------------------------------------------------------------------------
module tb_blit_mem_arbiter;

    localparam int ADDR_W = 26;

    logic              clock;
    logic              reset_n;
    logic              cpu_request;
    logic              cpu_write;
    logic [ADDR_W-1:0] cpu_address;
    logic [31:0]       cpu_wdata;
    logic [3:0]        cpu_byte_en;
    logic              cpu_ack;
    logic [31:0]       cpu_rdata;
    logic              cpu_valid;
    logic              cpu_complete;
    logic              blitr_request;
    logic [ADDR_W-1:0] blitr_address;
    logic              blitr_ack;
    logic [31:0]       blitr_rdata;
    logic              blitr_valid;
    logic              blitr_complete;
    logic              blitw_request;
    logic [ADDR_W-1:0] blitw_address;
    logic [31:0]       blitw_wdata;
    logic [3:0]        blitw_byte_en;
    logic              blitw_ack;
    logic              mem_request;
    logic              mem_write;
    logic [ADDR_W-1:0] mem_address;
    logic [31:0]       mem_wdata;
    logic [3:0]        mem_byte_en;
    logic              mem_ack;
    logic [31:0]       mem_rdata;
    logic              mem_valid;
    logic              mem_complete;
    logic              ack_en;
`ifdef BLIT_MEM_ARBITER_STATS_EN
    logic              stat_clear;
    logic [31:0]       stat_cpu_grants;
    logic [31:0]       stat_blitr_grants;
    logic [31:0]       stat_blitw_words;
    logic [31:0]       stat_blit_wait_cycles;
`endif

    int vec_cnt = 0;
    int err_cnt = 0;

    // Controller model: accepts any presented request while ack_en is set.
    assign mem_ack = mem_request & ack_en;

    blit_mem_arbiter #(.WRITE_RUN(8), .ADDR_W(ADDR_W)) dut (
        .clock          (clock),
        .reset_n        (reset_n),
        .cpu_request    (cpu_request),
        .cpu_write      (cpu_write),
        .cpu_address    (cpu_address),
        .cpu_wdata      (cpu_wdata),
        .cpu_byte_en    (cpu_byte_en),
        .cpu_ack        (cpu_ack),
        .cpu_rdata      (cpu_rdata),
        .cpu_valid      (cpu_valid),
        .cpu_complete   (cpu_complete),
        .blitr_request  (blitr_request),
        .blitr_address  (blitr_address),
        .blitr_ack      (blitr_ack),
        .blitr_rdata    (blitr_rdata),
        .blitr_valid    (blitr_valid),
        .blitr_complete (blitr_complete),
        .blitw_request  (blitw_request),
        .blitw_address  (blitw_address),
        .blitw_wdata    (blitw_wdata),
        .blitw_byte_en  (blitw_byte_en),
        .blitw_ack      (blitw_ack),
        .mem_request    (mem_request),
        .mem_write      (mem_write),
        .mem_address    (mem_address),
        .mem_wdata      (mem_wdata),
        .mem_byte_en    (mem_byte_en),
        .mem_ack        (mem_ack),
        .mem_rdata      (mem_rdata),
        .mem_valid      (mem_valid),
        .mem_complete   (mem_complete)
`ifdef BLIT_MEM_ARBITER_STATS_EN
        ,
        .stat_clear            (stat_clear),
        .stat_cpu_grants       (stat_cpu_grants),
        .stat_blitr_grants     (stat_blitr_grants),
        .stat_blitw_words      (stat_blitw_words),
        .stat_blit_wait_cycles (stat_blit_wait_cycles)
`endif
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic do_reset();
        cpu_request   = 1'b0;
        blitr_request = 1'b0;
        blitw_request = 1'b0;
        mem_valid     = 1'b0;
        mem_complete  = 1'b0;
        ack_en        = 1'b0;
`ifdef BLIT_MEM_ARBITER_STATS_EN
        stat_clear    = 1'b0;
`endif
        @(negedge clock);
        reset_n = 1'b0;
        @(negedge clock);
        reset_n = 1'b1;
    endtask

    task automatic test_reset();
        logic [8:0] flags;
        reset_n       = 1'b0;
        cpu_request   = 1'b1;
        blitr_request = 1'b1;
        blitw_request = 1'b1;
        cpu_write     = 1'b0;
        cpu_address   = 26'h0000100;
        blitr_address = 26'h0000200;
        blitw_address = 26'h0000300;
        cpu_wdata     = 32'h1234_5678;
        blitw_wdata   = 32'h8765_4321;
        cpu_byte_en   = 4'b1111;
        blitw_byte_en = 4'b1111;
        mem_rdata     = 32'hCAFE_F00D;
        mem_valid     = 1'b1;
        mem_complete  = 1'b1;
        ack_en        = 1'b1;
        repeat (2) @(negedge clock);
        #1;
        flags = {mem_request, mem_write, cpu_ack, blitr_ack, blitw_ack,
                 cpu_valid, cpu_complete, blitr_valid, blitr_complete};
        vec_cnt++;
        if (flags !== 9'd0) begin
            err_cnt++;
            $display("FAIL rst_flags: got %b want %b", flags, 9'd0);
        end
        vec_cnt++;
        if ({mem_address, mem_wdata, mem_byte_en, cpu_rdata, blitr_rdata} !== '0) begin
            err_cnt++;
            $display("FAIL rst_data: got addr %h wdata %h be %h crd %h brd %h want all 0",
                     mem_address, mem_wdata, mem_byte_en, cpu_rdata, blitr_rdata);
        end
        mem_valid    = 1'b0;
        mem_complete = 1'b0;
        ack_en       = 1'b0;
        @(negedge clock);
        reset_n = 1'b1;
        #1;
        vec_cnt++;
        if (mem_request !== 1'b0) begin
            err_cnt++;
            $display("FAIL rel_idle: got mem_request %b want 0", mem_request);
        end
        @(negedge clock);
        #1;
        vec_cnt++;
        if (mem_request !== 1'b1) begin
            err_cnt++;
            $display("FAIL first_grant_req: got mem_request %b want 1", mem_request);
        end
        vec_cnt++;
        if (mem_address !== 26'h0000100) begin
            err_cnt++;
            $display("FAIL first_grant_addr: got %h want %h", mem_address, 26'h0000100);
        end
        do_reset();
    endtask

    task automatic test_cpu_read();
        @(negedge clock);
        cpu_request = 1'b1;
        cpu_write   = 1'b0;
        cpu_address = 26'h0000100;
        ack_en      = 1'b1;
        @(negedge clock);
        #1;
        vec_cnt++;
        if (cpu_ack !== 1'b1) begin
            err_cnt++;
            $display("FAIL cpu_rd_ack: got %b want 1", cpu_ack);
        end
        vec_cnt++;
        if ({mem_write, mem_byte_en} !== 5'b01111) begin
            err_cnt++;
            $display("FAIL cpu_rd_cmd: got write/be %b want %b", {mem_write, mem_byte_en}, 5'b01111);
        end
        @(negedge clock);
        cpu_request  = 1'b0;
        ack_en       = 1'b0;
        mem_rdata    = 32'hDEAD_BEEF;
        mem_valid    = 1'b1;
        mem_complete = 1'b1;
        #1;
        vec_cnt++;
        if ({cpu_valid, cpu_complete, blitr_valid, blitr_complete} !== 4'b1100) begin
            err_cnt++;
            $display("FAIL cpu_rd_flags: got %b want %b",
                     {cpu_valid, cpu_complete, blitr_valid, blitr_complete}, 4'b1100);
        end
        vec_cnt++;
        if (cpu_rdata !== 32'hDEAD_BEEF) begin
            err_cnt++;
            $display("FAIL cpu_rd_data: got %h want %h", cpu_rdata, 32'hDEAD_BEEF);
        end
        // Back in IDLE with mem_valid still high: nothing may be forwarded.
        @(negedge clock);
        #1;
        vec_cnt++;
        if ({cpu_valid, blitr_valid} !== 2'b00) begin
            err_cnt++;
            $display("FAIL stray_valid: got %b want 00", {cpu_valid, blitr_valid});
        end
        mem_valid    = 1'b0;
        mem_complete = 1'b0;
    endtask

    task automatic test_blitw_run();
        logic [22:0] exp_pat;
        int          idx;
        int          acks;
        logic        last;
        do_reset();
        // One bit per cycle: IDLE, 8 words, IDLE, 8 words, IDLE, 4 words.
        exp_pat       = 23'b1111_0_1111_1111_0_1111_1111_0;
        idx           = 0;
        acks          = 0;
        last          = 1'b0;
        blitw_address = 26'h0000300;
        blitw_byte_en = 4'b1100;
        blitw_wdata   = 32'hA000_0000;
        ack_en        = 1'b1;
        @(negedge clock);
        blitw_request = 1'b1;
        for (int c = 0; c < 23; c++) begin
            if (c > 0) @(negedge clock);
            if (last) begin
                idx++;
                blitw_wdata = 32'hA000_0000 + 32'(idx);
            end
            #1;
            vec_cnt++;
            if (blitw_ack !== exp_pat[c]) begin
                err_cnt++;
                $display("FAIL run_ack cycle %0d: got %b want %b", c, blitw_ack, exp_pat[c]);
            end
            if (blitw_ack) begin
                acks++;
                vec_cnt++;
                if ({mem_write, mem_byte_en, mem_wdata} !== {1'b1, 4'b1100, 32'hA000_0000 + 32'(idx)}) begin
                    err_cnt++;
                    $display("FAIL run_word %0d: got w %b be %b data %h want w 1 be 1100 data %h",
                             idx, mem_write, mem_byte_en, mem_wdata, 32'hA000_0000 + 32'(idx));
                end
            end
            last = blitw_ack;
        end
        @(negedge clock);
        blitw_request = 1'b0;
        #1;
        vec_cnt++;
        if (acks !== 20) begin
            err_cnt++;
            $display("FAIL run_total: got %0d acks want 20", acks);
        end
        vec_cnt++;
        if (mem_request !== 1'b0) begin
            err_cnt++;
            $display("FAIL run_drained: got mem_request %b want 0", mem_request);
        end
    endtask

    task automatic test_blitr_midrun();
        do_reset();
        blitr_address = 26'h0000200;
        blitw_wdata   = 32'h0000_5A5A;
        ack_en        = 1'b1;
        @(negedge clock);
        blitw_request = 1'b1;
        @(negedge clock);
        @(negedge clock);
        @(negedge clock);
        blitr_request = 1'b1;
        #1;
        vec_cnt++;
        if (blitw_ack !== 1'b1) begin
            err_cnt++;
            $display("FAIL mid_last_write: got blitw_ack %b want 1", blitw_ack);
        end
        @(negedge clock);
        #1;
        vec_cnt++;
        if (mem_request !== 1'b0) begin
            err_cnt++;
            $display("FAIL mid_idle_gap: got mem_request %b want 0", mem_request);
        end
        @(negedge clock);
        #1;
        vec_cnt++;
        if ({blitr_ack, blitw_ack, cpu_ack} !== 3'b100) begin
            err_cnt++;
            $display("FAIL mid_blitr_grant: got r/w/c acks %b want 100", {blitr_ack, blitw_ack, cpu_ack});
        end
        vec_cnt++;
        if (mem_address !== 26'h0000200) begin
            err_cnt++;
            $display("FAIL mid_blitr_addr: got %h want %h", mem_address, 26'h0000200);
        end
        for (int b = 0; b < 8; b++) begin
            @(negedge clock);
            blitr_request = 1'b0;
            mem_valid     = 1'b1;
            mem_complete  = (b == 7);
            mem_rdata     = 32'h1111_0000 + 32'(b);
            #1;
            vec_cnt++;
            if ({blitr_valid, blitr_complete, cpu_valid, blitw_ack} !== {1'b1, (b == 7), 2'b00}) begin
                err_cnt++;
                $display("FAIL beat %0d flags: got %b want %b", b,
                         {blitr_valid, blitr_complete, cpu_valid, blitw_ack}, {1'b1, (b == 7), 2'b00});
            end
            vec_cnt++;
            if (blitr_rdata !== 32'h1111_0000 + 32'(b)) begin
                err_cnt++;
                $display("FAIL beat %0d data: got %h want %h", b, blitr_rdata, 32'h1111_0000 + 32'(b));
            end
        end
        @(negedge clock);
        mem_valid    = 1'b0;
        mem_complete = 1'b0;
        #1;
        vec_cnt++;
        if (blitr_valid !== 1'b0) begin
            err_cnt++;
            $display("FAIL mid_after_burst: got blitr_valid %b want 0", blitr_valid);
        end
        @(negedge clock);
        #1;
        vec_cnt++;
        if (blitw_ack !== 1'b1) begin
            err_cnt++;
            $display("FAIL mid_blitw_resume: got blitw_ack %b want 1", blitw_ack);
        end
        blitw_request = 1'b0;
    endtask

    task automatic test_all_three();
        logic [1:0] got [6];
        logic [1:0] exp_seq [6];
        int         n;
        logic       prev_r;
        do_reset();
        exp_seq     = '{2'd1, 2'd2, 2'd3, 2'd1, 2'd2, 2'd3};
        got         = '{2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0};
        n           = 0;
        prev_r      = 1'b0;
        cpu_write   = 1'b1;
        cpu_wdata   = 32'h0BAD_F00D;
        cpu_byte_en = 4'b0101;
        ack_en      = 1'b1;
        @(negedge clock);
        cpu_request   = 1'b1;
        blitr_request = 1'b1;
        blitw_request = 1'b1;
        for (int c = 0; c < 20 && n < 6; c++) begin
            @(negedge clock);
            // One-beat line fill returned the cycle after each BLITR accept.
            mem_valid    = prev_r;
            mem_complete = prev_r;
            mem_rdata    = 32'h5555_0000 + 32'(c);
            #1;
            if (cpu_ack) begin
                if (n < 6) got[n] = 2'd1;
                n++;
                vec_cnt++;
                if ({mem_write, mem_byte_en, mem_wdata} !== {1'b1, 4'b0101, 32'h0BAD_F00D}) begin
                    err_cnt++;
                    $display("FAIL all3_cpu_cmd: got w %b be %b data %h want w 1 be 0101 data 0badf00d",
                             mem_write, mem_byte_en, mem_wdata);
                end
            end
            if (blitr_ack) begin
                if (n < 6) got[n] = 2'd2;
                n++;
            end
            if (blitw_ack) begin
                if (n < 6) got[n] = 2'd3;
                n++;
            end
            prev_r = blitr_ack;
        end
        vec_cnt++;
        if (n !== 6) begin
            err_cnt++;
            $display("FAIL all3_count: got %0d grants within budget want 6", n);
        end
        for (int i = 0; i < 6; i++) begin
            vec_cnt++;
            if (got[i] !== exp_seq[i]) begin
                err_cnt++;
                $display("FAIL all3_order grant %0d: got %0d want %0d", i, got[i], exp_seq[i]);
            end
        end
        cpu_request   = 1'b0;
        blitr_request = 1'b0;
        blitw_request = 1'b0;
        mem_valid     = 1'b0;
        mem_complete  = 1'b0;
    endtask

    task automatic test_reset_rdata();
        logic [8:0] flags;
        do_reset();
        cpu_write   = 1'b0;
        cpu_address = 26'h0000440;
        @(negedge clock);
        cpu_request = 1'b1;
        ack_en      = 1'b1;
        @(negedge clock);
        #1;
        vec_cnt++;
        if (cpu_ack !== 1'b1) begin
            err_cnt++;
            $display("FAIL rrd_ack: got %b want 1", cpu_ack);
        end
        @(negedge clock);
        cpu_request  = 1'b0;
        ack_en       = 1'b0;
        mem_valid    = 1'b1;
        mem_complete = 1'b0;
        mem_rdata    = 32'h0F0F_0F0F;
        #1;
        vec_cnt++;
        if (cpu_valid !== 1'b1) begin
            err_cnt++;
            $display("FAIL rrd_pre_valid: got %b want 1", cpu_valid);
        end
        #1;
        reset_n = 1'b0;
        #1;
        flags = {mem_request, mem_write, cpu_ack, blitr_ack, blitw_ack,
                 cpu_valid, cpu_complete, blitr_valid, blitr_complete};
        vec_cnt++;
        if ({flags, cpu_rdata} !== 41'd0) begin
            err_cnt++;
            $display("FAIL rrd_flags: got flags %b rdata %h want 0", flags, cpu_rdata);
        end
        mem_valid = 1'b0;
        @(negedge clock);
        reset_n     = 1'b1;
        cpu_request = 1'b1;
        ack_en      = 1'b1;
        #1;
        vec_cnt++;
        if (mem_request !== 1'b0) begin
            err_cnt++;
            $display("FAIL rrd_rel_idle: got mem_request %b want 0", mem_request);
        end
        @(negedge clock);
        #1;
        vec_cnt++;
        if ({mem_request, cpu_ack, mem_address} !== {2'b11, 26'h0000440}) begin
            err_cnt++;
            $display("FAIL rrd_new_grant: got req %b ack %b addr %h want 1 1 %h",
                     mem_request, cpu_ack, mem_address, 26'h0000440);
        end
        @(negedge clock);
        cpu_request  = 1'b0;
        ack_en       = 1'b0;
        mem_valid    = 1'b1;
        mem_complete = 1'b1;
        mem_rdata    = 32'h1234_5678;
        #1;
        vec_cnt++;
        if ({cpu_valid, cpu_complete, cpu_rdata} !== {2'b11, 32'h1234_5678}) begin
            err_cnt++;
            $display("FAIL rrd_new_data: got v %b c %b data %h want 1 1 12345678",
                     cpu_valid, cpu_complete, cpu_rdata);
        end
        @(negedge clock);
        mem_valid    = 1'b0;
        mem_complete = 1'b0;
    endtask

`ifdef BLIT_MEM_ARBITER_STATS_EN
    task automatic test_stats();
        do_reset();
        #1;
        vec_cnt++;
        if ({stat_cpu_grants, stat_blitr_grants, stat_blitw_words, stat_blit_wait_cycles} !== 128'd0) begin
            err_cnt++;
            $display("FAIL st_reset: got %h %h %h %h want 0", stat_cpu_grants, stat_blitr_grants,
                     stat_blitw_words, stat_blit_wait_cycles);
        end
        cpu_write = 1'b1;
        @(negedge clock);
        cpu_request = 1'b1;
        ack_en      = 1'b1;
        @(negedge clock);
        @(negedge clock);
        cpu_request = 1'b0;
        #1;
        vec_cnt++;
        if (stat_cpu_grants !== 32'd1) begin
            err_cnt++;
            $display("FAIL st_cpu_inc: got %0d want 1", stat_cpu_grants);
        end
        @(negedge clock);
        cpu_request = 1'b1;
        @(negedge clock);
        stat_clear = 1'b1;
        #1;
        vec_cnt++;
        if (cpu_ack !== 1'b1) begin
            err_cnt++;
            $display("FAIL st_clr_ack: got %b want 1", cpu_ack);
        end
        @(negedge clock);
        stat_clear  = 1'b0;
        cpu_request = 1'b0;
        #1;
        vec_cnt++;
        if (stat_cpu_grants !== 32'd0) begin
            err_cnt++;
            $display("FAIL st_clr_wins: got %0d want 0", stat_cpu_grants);
        end
    endtask
`endif

    initial begin
        reset_n       = 1'b0;
        cpu_request   = 1'b0;
        blitr_request = 1'b0;
        blitw_request = 1'b0;
        cpu_write     = 1'b0;
        cpu_address   = '0;
        cpu_wdata     = 32'd0;
        cpu_byte_en   = 4'd0;
        blitr_address = '0;
        blitw_address = '0;
        blitw_wdata   = 32'd0;
        blitw_byte_en = 4'd0;
        mem_rdata     = 32'd0;
        mem_valid     = 1'b0;
        mem_complete  = 1'b0;
        ack_en        = 1'b0;
`ifdef BLIT_MEM_ARBITER_STATS_EN
        stat_clear    = 1'b0;
`endif
        test_reset();
        test_cpu_read();
        test_blitw_run();
        test_blitr_midrun();
        test_all_three();
        test_reset_rdata();
`ifdef BLIT_MEM_ARBITER_STATS_EN
        test_stats();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
